// File: rtl/spi_flash_pkg.sv
// ============================================================================
// Module      : spi_flash_pkg
// Description : Shared opcodes, loader FSM state encoding and destination ids
//               for the SPI flash loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_flash_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_WAKE      = 8'hAB;

  localparam int DEST_IMAGE = 0;
  localparam int DEST_TABLE = 1;

  typedef enum logic [2:0] {
    ST_STARTUP   = 3'd0,
    ST_WAKE      = 3'd1,
    ST_WAKE_WAIT = 3'd2,
    ST_IDLE      = 3'd3,
    ST_CMD       = 3'd4,
    ST_DATA      = 3'd5,
    ST_GAP       = 3'd6
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_byte_shifter.sv
// ============================================================================
// Module      : spi_byte_shifter
// Description : Mode-0 SPI byte engine with clk/(2*CLK_DIV) SCK; bytes chain
//               back-to-back when the next byte_start arrives with byte_done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_byte_shifter #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       i_byte_start,
  input  logic [7:0] i_tx_byte,
  input  logic       i_miso,
  output logic       o_sck,
  output logic       o_mosi,
  output logic       o_byte_done,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_byte
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic             r_active;
  logic [DIV_W-1:0] r_div;
  logic [3:0]       r_half;
  logic             r_sck;
  logic [7:0]       r_tx;
  logic [7:0]       r_rx;
  logic             r_rx_valid;
  logic             w_tick;
  logic             w_done;
  logic             w_load;

  assign w_tick = r_active && (r_div == DIV_W'(CLK_DIV - 1));
  assign w_done = w_tick && (r_half == 4'd15);
  // A new byte may load on the final falling edge so SCK never pauses
  assign w_load = i_byte_start && (!r_active || w_done);

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_active   <= 1'b0;
      r_div      <= '0;
      r_half     <= '0;
      r_sck      <= 1'b0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_load) begin
        r_active <= 1'b1;
        r_div    <= '0;
        r_half   <= '0;
        r_sck    <= 1'b0;
        r_tx     <= i_tx_byte;
      end else if (r_active) begin
        if (w_tick) begin
          r_div  <= '0;
          r_half <= r_half + 4'd1;
          if (!r_half[0]) begin
            r_sck <= 1'b1;
            r_rx  <= {r_rx[6:0], i_miso};
            if (r_half == 4'd14) r_rx_valid <= 1'b1;
          end else begin
            r_sck <= 1'b0;
            r_tx  <= {r_tx[6:0], 1'b0};
            if (r_half == 4'd15) r_active <= 1'b0;
          end
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
    end
  end

  assign o_sck       = r_sck;
  assign o_mosi      = r_tx[7];
  assign o_byte_done = w_done;
  assign o_rx_valid  = r_rx_valid;
  assign o_rx_byte   = r_rx;

endmodule

`default_nettype wire

// File: rtl/spi_flash_loader.sv
// ============================================================================
// Module      : spi_flash_loader
// Description : Wakes the SPI flash, then copies flash regions into a selected
//               on-chip memory on each start request. FAST_READ_EN selects
//               opcode 0x0B with one dummy byte instead of 0x03.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_flash_loader
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV        = 2,
  parameter int ADDR_W         = 16,
  parameter int LEN_W          = 17,
  parameter int NUM_DEST       = 2,
  parameter int STARTUP_CYCLES = 100,
  parameter int WAKE_CYCLES    = 64,
  parameter int CS_HIGH_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 start,
  input  logic [23:0]          flash_addr,
  input  logic [ADDR_W-1:0]    dest_addr,
  input  logic [((NUM_DEST > 1) ? $clog2(NUM_DEST) : 1)-1:0] dest_sel,
  input  logic [LEN_W-1:0]     length,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [7:0]           mem_data,
  output logic [NUM_DEST-1:0]  mem_we,
  output logic                 spi_clk,
  output logic                 spi_mosi,
  input  logic                 spi_miso,
  output logic                 spi_cs
);

  localparam int SEL_W   = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
  localparam int CNT_MAX = (STARTUP_CYCLES > WAKE_CYCLES + CS_HIGH_CYCLES) ?
                           STARTUP_CYCLES : WAKE_CYCLES + CS_HIGH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
`ifdef FAST_READ_EN
  localparam logic [7:0] c_READ_OP  = OP_FAST_READ;
  localparam logic [2:0] c_LAST_HDR = 3'd4;
`else
  localparam logic [7:0] c_READ_OP  = OP_READ;
  localparam logic [2:0] c_LAST_HDR = 3'd3;
`endif

  loader_state_t       r_state, w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_hdr_idx;
  logic [LEN_W-1:0]    r_remaining;
  logic [23:0]         r_flash_addr;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [SEL_W-1:0]    r_dest_sel;
  logic                r_cs;
  logic                r_done;
  logic [NUM_DEST-1:0] r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [7:0]          r_mem_data;
  logic                w_byte_start;
  logic [7:0]          w_tx;
  logic [7:0]          w_hdr_next;
  logic                w_byte_done;
  logic                w_rx_valid;
  logic [7:0]          w_rx_byte;
  logic [NUM_DEST-1:0] w_we_lane;
  logic                w_accept;

  spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk          (clk),
    .rst_l        (rst_l),
    .i_byte_start (w_byte_start),
    .i_tx_byte    (w_tx),
    .i_miso       (spi_miso),
    .o_sck        (spi_clk),
    .o_mosi       (spi_mosi),
    .o_byte_done  (w_byte_done),
    .o_rx_valid   (w_rx_valid),
    .o_rx_byte    (w_rx_byte)
  );

  // An out-of-range dest_sel leaves every lane low
  for (genvar g = 0; g < NUM_DEST; g++) begin : g_we_lane
    assign w_we_lane[g] = (32'(r_dest_sel) == g);
  end

  assign w_accept = (r_state == ST_IDLE) && start;

  always_comb begin
    case (r_hdr_idx + 3'd1)
      3'd1:    w_hdr_next = r_flash_addr[23:16];
      3'd2:    w_hdr_next = r_flash_addr[15:8];
      3'd3:    w_hdr_next = r_flash_addr[7:0];
      default: w_hdr_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_l) r_state <= ST_STARTUP;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_byte_start = 1'b0;
    w_tx         = 8'h00;
    case (r_state)
      ST_STARTUP: begin
        if (r_cnt == CNT_W'(STARTUP_CYCLES - 1)) begin
          w_state_next = ST_WAKE;
          w_byte_start = 1'b1;
          w_tx         = OP_WAKE;
        end
      end
      ST_WAKE:
        if (w_byte_done) w_state_next = ST_WAKE_WAIT;
      // Wake wait also covers the chip-select high gap before the first read
      ST_WAKE_WAIT:
        if (r_cnt == CNT_W'(WAKE_CYCLES + CS_HIGH_CYCLES - 1)) w_state_next = ST_IDLE;
      ST_IDLE: begin
        if (start) begin
          if (length == '0) begin
            w_state_next = ST_GAP;
          end else begin
            w_state_next = ST_CMD;
            w_byte_start = 1'b1;
            w_tx         = c_READ_OP;
          end
        end
      end
      ST_CMD: begin
        if (w_byte_done) begin
          w_byte_start = 1'b1;
          if (r_hdr_idx == c_LAST_HDR) w_state_next = ST_DATA;
          else                         w_tx = w_hdr_next;
        end
      end
      ST_DATA: begin
        if (w_byte_done) begin
          if (r_remaining == LEN_W'(1)) w_state_next = ST_GAP;
          else                          w_byte_start = 1'b1;
        end
      end
      ST_GAP:
        if (r_cnt == CNT_W'(CS_HIGH_CYCLES - 1)) w_state_next = ST_IDLE;
      default: w_state_next = ST_STARTUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_cnt        <= '0;
      r_hdr_idx    <= '0;
      r_remaining  <= '0;
      r_flash_addr <= '0;
      r_cur_addr   <= '0;
      r_dest_sel   <= '0;
      r_cs         <= 1'b1;
      r_done       <= 1'b0;
      r_mem_we     <= '0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
    end else begin
      if (w_state_next != r_state) r_cnt <= '0;
      else                         r_cnt <= r_cnt + 1'b1;
      r_cs   <= !(w_state_next inside {ST_WAKE, ST_CMD, ST_DATA});
      r_done <= (r_state == ST_GAP) && (w_state_next == ST_IDLE);

      if (w_accept) begin
        r_flash_addr <= flash_addr;
        r_cur_addr   <= dest_addr;
        r_dest_sel   <= dest_sel;
        r_remaining  <= length;
        r_hdr_idx    <= '0;
        // Zero-length requests leave GAP on the very next edge
        if (length == '0) r_cnt <= CNT_W'(CS_HIGH_CYCLES - 1);
      end
      if (r_state == ST_CMD && w_byte_done) r_hdr_idx <= r_hdr_idx + 3'd1;
      if (r_state == ST_DATA && w_byte_done) r_remaining <= r_remaining - 1'b1;

      if (r_state == ST_DATA && w_rx_valid) begin
        r_mem_we   <= w_we_lane;
        r_mem_addr <= r_cur_addr;
        r_mem_data <= w_rx_byte;
        r_cur_addr <= r_cur_addr + 1'b1;
      end else begin
        r_mem_we   <= '0;
      end
    end
  end

  assign ready    = (r_state == ST_IDLE);
  assign busy     = (r_state inside {ST_CMD, ST_DATA, ST_GAP});
  assign done     = r_done;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign spi_cs   = r_cs;

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_loader.sv
// ============================================================================
// Module      : tb_spi_flash_loader
// Description : Directed bench for spi_flash_loader with a mode-0 flash model
//               whose read data is the low byte of the flash byte address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_flash_loader;

  localparam int CLK_DIV = 2;
  localparam int S_CYC = 100, W_CYC = 64, G_CYC = 4;
  localparam int READY_LAT = S_CYC + 16 * CLK_DIV + W_CYC + G_CYC;
`ifdef FAST_READ_EN
  localparam int HDR = 5;
  localparam logic [7:0] OPC = 8'h0B;
`else
  localparam int HDR = 4;
  localparam logic [7:0] OPC = 8'h03;
`endif
  localparam int HDR_BITS = HDR * 8;

  logic        clk = 1'b0, rst_l = 1'b0, start = 1'b0;
  logic [23:0] flash_addr = '0;
  logic [15:0] dest_addr = '0;
  logic [0:0]  dest_sel = '0;
  logic [16:0] length = '0;
  logic        ready, busy, done, spi_clk, spi_mosi, spi_cs;
  logic        spi_miso = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic [1:0]  mem_we;

  spi_flash_loader #(
    .CLK_DIV(CLK_DIV), .ADDR_W(16), .LEN_W(17), .NUM_DEST(2),
    .STARTUP_CYCLES(S_CYC), .WAKE_CYCLES(W_CYC), .CS_HIGH_CYCLES(G_CYC)
  ) dut (
    .clk(clk), .rst_l(rst_l), .start(start), .flash_addr(flash_addr),
    .dest_addr(dest_addr), .dest_sel(dest_sel), .length(length),
    .ready(ready), .busy(busy), .done(done), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_we(mem_we), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs(spi_cs)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Flash model
  int          bit_cnt = 0, frames = 0, sck_rises = 0;
  logic [7:0]  rx_sh = '0;
  logic [7:0]  fr_bytes[$];
  logic [7:0]  mosi_log[$];
  logic [23:0] f_addr = '0;

  always @(negedge spi_cs) begin
    bit_cnt = 0;
    fr_bytes.delete();
    frames++;
  end

  always @(posedge spi_clk) begin
    sck_rises++;
    if (spi_cs === 1'b0) begin
      rx_sh = {rx_sh[6:0], spi_mosi};
      bit_cnt++;
      if (bit_cnt % 8 == 0) begin
        fr_bytes.push_back(rx_sh);
        mosi_log.push_back(rx_sh);
      end
      if (bit_cnt == 32) f_addr = {fr_bytes[1], fr_bytes[2], fr_bytes[3]};
    end
  end

  always @(negedge spi_clk) begin : model_tx
    int idx;
    logic [7:0] b;
    if (spi_cs === 1'b0 && bit_cnt >= HDR_BITS) begin
      idx = bit_cnt - HDR_BITS;
      b = f_addr[7:0] + 8'(idx / 8);
      spi_miso = b[7 - (idx % 8)];
    end
  end

  // Write / handshake monitor
  typedef struct packed { logic [1:0] we; logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t wr_log[$];
  int  done_cnt = 0, overlap = 0;

  always @(negedge clk) begin
    if (rst_l) begin
      if (mem_we != 2'b00) wr_log.push_back('{mem_we, mem_addr, mem_data});
      if (done) done_cnt++;
      if (done && (busy || !ready)) overlap++;
    end
  end

  task automatic clear_logs();
    wr_log.delete();
    mosi_log.delete();
    done_cnt = 0;
    overlap = 0;
    frames = 0;
    sck_rises = 0;
  endtask

  typedef struct {
    logic [23:0] faddr;
    logic [15:0] daddr;
    logic [0:0]  dsel;
    logic [16:0] len;
    int          exp_n_we;
    logic [7:0]  exp_first;
    logic [15:0] exp_last_addr;
  } vec_t;

  vec_t vecs[5];

  task automatic reset_and_wake(input string tag);
    int k;
    rst_l = 1'b0;
    repeat (4) @(negedge clk);
    clear_logs();
    chk({tag, "_rst_cs"}, spi_cs, 1'b1);
    chk({tag, "_rst_sck"}, spi_clk, 1'b0);
    chk({tag, "_rst_ready_busy_done"}, {ready, busy, done}, 3'b000);
    chk({tag, "_rst_mem"}, {mem_we, mem_addr, mem_data, spi_mosi}, '0);
    rst_l = 1'b1;
    k = 0;
    while (k < 2000) begin
      @(posedge clk);
      #1;
      k++;
      if (k == 50) begin
        start = 1'b1; flash_addr = 24'h000040; dest_addr = 16'h0; dest_sel = 1'b0; length = 17'd5;
      end
      if (k == 51) start = 1'b0;
      if (ready) break;
    end
    chk({tag, "_ready_latency"}, k, READY_LAT);
    @(negedge clk);
    chk({tag, "_wake_frames"}, frames, 1);
    chk({tag, "_wake_bytes"}, mosi_log.size(), 1);
    if (mosi_log.size() > 0) chk({tag, "_wake_opcode"}, mosi_log[0], 8'hAB);
    chk({tag, "_early_start_ignored"}, {busy, 8'(wr_log.size()), 8'(done_cnt)}, '0);
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    logic [1:0] exp_we;
    logic [7:0] hdr_exp[5];
    exp_we = v.dsel ? 2'b10 : 2'b01;
    hdr_exp[0] = OPC; hdr_exp[1] = v.faddr[23:16]; hdr_exp[2] = v.faddr[15:8];
    hdr_exp[3] = v.faddr[7:0]; hdr_exp[4] = 8'h00;
    @(negedge clk);
    clear_logs();
    start = 1'b1; flash_addr = v.faddr; dest_addr = v.daddr; dest_sel = v.dsel; length = v.len;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", {busy, ready}, 2'b10);
    if (v.len == 0) begin
      chk("zero_len_no_early_done", done, 1'b0);
      @(negedge clk);
      chk("zero_len_done_next", {done, busy, ready}, 3'b101);
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3 && v.len != 0) begin
        // A second request while busy must be dropped
        start = 1'b1; dest_sel = ~v.dsel; dest_addr = 16'hAAAA;
      end
      if (cyc == 4) start = 1'b0;
    end
    chk("done_seen", done_cnt != 0, 1'b1);
    repeat (6) @(negedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("done_busy_overlap", overlap, 0);
    chk("n_writes", wr_log.size(), v.exp_n_we);
    for (int i = 0; i < wr_log.size(); i++) begin
      chk("we_lane", wr_log[i].we, exp_we);
      chk("we_addr", wr_log[i].a, 16'(v.daddr + 16'(i)));
      chk("we_data", wr_log[i].d, 8'(v.exp_first + 8'(i)));
    end
    if (wr_log.size() > 0) chk("last_addr", wr_log[wr_log.size() - 1].a, v.exp_last_addr);
    chk("frames", frames, (v.len == 0) ? 0 : 1);
    if (v.len == 0) chk("zero_len_sck", sck_rises, 0);
    chk("mosi_bytes", mosi_log.size(), (v.len == 0) ? 0 : HDR + int'(v.len));
    for (int i = 0; i < mosi_log.size(); i++) begin
      if (i < HDR) chk("hdr_byte", mosi_log[i], hdr_exp[i]);
      else if (mosi_log[i] != 8'h00) chk("data_mosi_zero", mosi_log[i], 8'h00);
    end
    chk("idle_pins", {spi_cs, spi_clk, ready, busy}, 4'b1010);
  endtask

  initial begin
    int cyc, n_before;
    vecs[0] = '{24'h020000, 16'h0000, 1'b0, 17'd256, 256, 8'h00, 16'h00FF};
    vecs[1] = '{24'h000010, 16'hFFFE, 1'b1, 17'd4,   4,   8'h10, 16'h0001};
    vecs[2] = '{24'h000000, 16'h1234, 1'b0, 17'd0,   0,   8'h00, 16'h0000};
    vecs[3] = '{24'h0000F0, 16'h0100, 1'b1, 17'd20,  20,  8'hF0, 16'h0113};
    vecs[4] = '{24'h123456, 16'h8000, 1'b0, 17'd2,   2,   8'h56, 16'h8001};

    reset_and_wake("boot");
    for (int i = 0; i < 3; i++) run_vec(vecs[i]);

    // Reset in the middle of a data phase
    @(negedge clk);
    clear_logs();
    start = 1'b1; flash_addr = 24'h000100; dest_addr = 16'h0200; dest_sel = 1'b0; length = 17'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; flash_addr = 24'h00FF00; dest_addr = 16'h7000; dest_sel = 1'b1; length = 17'd3;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (wr_log.size() < 5 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_writes_started", wr_log.size() >= 5, 1'b1);
    rst_l = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_cs_we", {spi_cs, mem_we, spi_clk}, 4'b1000);
    chk("mid_rst_flags", {ready, busy, done}, 3'b000);
    n_before = wr_log.size();
    repeat (3) @(negedge clk);
    chk("mid_no_more_we", wr_log.size(), n_before);
    chk("mid_single_frame", frames, 1);
    for (int i = 0; i < wr_log.size(); i++) begin
      chk("mid_we_lane", wr_log[i].we, 2'b01);
      chk("mid_we_addr", wr_log[i].a, 16'(16'h0200 + 16'(i)));
      chk("mid_we_data", wr_log[i].d, 8'(i));
    end
    reset_and_wake("rewake");
    for (int i = 3; i < 5; i++) run_vec(vecs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
